// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register: main entry feeds the consumer, skid entry
// absorbs the one extra payload accepted in the cycle the consumer stalls.
module pipe_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             in_ready_reg, in_ready_next;
  logic             out_valid_reg, out_valid_next;
  logic [1:0]       count_reg, count_next;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid_i && in_ready_reg;
  assign out_xfer = out_valid_reg && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      count_reg     <= 2'd0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;

    unique case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          main_next  = in_data_i;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_next = in_data_i;
        end else if (in_xfer) begin
          skid_next  = in_data_i;
          state_next = FULL;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_next  = skid_reg;
          state_next = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase

    // Redirect wins over any handshake; held payloads are simply forgotten.
    if (flush_i) begin
      state_next = EMPTY;
      main_next  = main_reg;
      skid_next  = skid_reg;
    end

    // Status flags are registered from the next state so no input reaches an output.
    in_ready_next  = (state_next != FULL);
    out_valid_next = (state_next != EMPTY);
    count_next     = state_next;
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign out_data_o  = main_reg;
  assign count_o     = count_reg;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed scenarios plus random traffic checked
// against a two-slot queue model of the stage.
module tb_pipe_skid_buffer;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [WIDTH-1:0] out_data_o;
  logic [1:0]       count_o;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];       // model contents, head = payload on the output
  logic [WIDTH-1:0] emitted[$];  // payloads the consumer actually took
  logic [WIDTH-1:0] exp_seq[$];

  always #5 clk = ~clk;

  pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .count_o(count_o)
  );

  // Drive one cycle, advance the model at the edge, return 1 time unit after it.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    logic acc, pop;
    in_valid_i = v; in_data_i = d; out_ready_i = r; flush_i = f;
    if (out_valid_o && r) emitted.push_back(out_data_o);
    acc = v && (mq.size() < 2);
    pop = r && (mq.size() > 0);
    @(posedge clk);
    if (f) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    #1;
  endtask

  function automatic bit seq_matches();
    if (emitted.size() != exp_seq.size()) return 1'b0;
    foreach (exp_seq[i]) if (emitted[i] !== exp_seq[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hDEADBEEF; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== '0 || in_ready_o !== 1'b1 || count_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h ready=%b count=%0d, need 0/0/1/0",
               out_valid_o, out_data_o, in_ready_o, count_o);
    end
    rst_n = 1'b1;
    mq.delete();
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'hDEADBEEF || count_o !== 2'd1) begin
      errors++;
      $display("FAIL reset_first_load: valid=%b data=%h count=%0d, need 1/deadbeef/1",
               out_valid_o, out_data_o, count_o);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_drain: valid=%b, need 0", out_valid_o);
    end
  endtask

  task automatic test_streaming();
    emitted.delete();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
      checks++;
      if (out_data_o !== WIDTH'(i) || out_valid_o !== 1'b1 || count_o !== 2'd1 || in_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: data=%h valid=%b count=%0d ready=%b, need %h/1/1/1",
                 i, out_data_o, out_valid_o, count_o, in_ready_o, i);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    exp_seq = '{32'h1, 32'h2, 32'h3, 32'h4};
    checks++;
    if (!seq_matches()) begin
      errors++;
      $display("FAIL stream_order: got %0d payloads, need 1,2,3,4", emitted.size());
    end
  endtask

  task automatic test_stall_skid();
    emitted.delete();
    cycle(1'b1, 32'hA, 1'b1, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    checks++;
    if (count_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o !== 32'hA) begin
      errors++;
      $display("FAIL skid_full: count=%0d ready=%b data=%h, need 2/0/a", count_o, in_ready_o, out_data_o);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'hC, 1'b0, 1'b0);
      checks++;
      if (out_data_o !== 32'hA || out_valid_o !== 1'b1 || count_o !== 2'd2 || in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: data=%h valid=%b count=%0d ready=%b, need a/1/2/0",
                 i, out_data_o, out_valid_o, count_o, in_ready_o);
      end
    end
    cycle(1'b1, 32'hC, 1'b1, 1'b0);
    checks++;
    if (out_data_o !== 32'hB || count_o !== 2'd1) begin
      errors++;
      $display("FAIL skid_drain: data=%h count=%0d, need b/1", out_data_o, count_o);
    end
    cycle(1'b1, 32'hC, 1'b1, 1'b0);
    checks++;
    if (out_data_o !== 32'hC || count_o !== 2'd1) begin
      errors++;
      $display("FAIL skid_next: data=%h count=%0d, need c/1", out_data_o, count_o);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    exp_seq = '{32'hA, 32'hB, 32'hC};
    checks++;
    if (!seq_matches() || count_o !== 2'd0) begin
      errors++;
      $display("FAIL skid_order: got %0d payloads count=%0d, need a,b,c and 0", emitted.size(), count_o);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h5, 1'b0, 1'b0);
    cycle(1'b1, 32'h6, 1'b0, 1'b0);
    emitted.delete();
    cycle(1'b1, 32'h7, 1'b0, 1'b1);
    checks++;
    if (count_o !== 2'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: count=%0d valid=%b ready=%b, need 0/0/1", count_o, out_valid_o, in_ready_o);
    end
    cycle(1'b1, 32'h8, 1'b1, 1'b0);
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h8) begin
      errors++;
      $display("FAIL flush_next: valid=%b data=%h, need 1/8", out_valid_o, out_data_o);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    exp_seq = '{32'h8};
    checks++;
    if (!seq_matches()) begin
      errors++;
      $display("FAIL flush_order: got %0d payloads, need only 8", emitted.size());
    end
  endtask

  task automatic test_random();
    logic v, r, f;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 24) == 0);
      cycle(v, WIDTH'($urandom), r, f);
      checks++;
      if (out_valid_o !== (mq.size() != 0) || count_o !== 2'(mq.size()) || in_ready_o !== (mq.size() < 2)) begin
        errors++;
        $display("FAIL rand_status_%0d: valid=%b count=%0d ready=%b, need count %0d",
                 i, out_valid_o, count_o, in_ready_o, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_data_o !== mq[0]) begin
          errors++;
          $display("FAIL rand_data_%0d: data=%h, need %h", i, out_data_o, mq[0]);
        end
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h12, 1'b0, 1'b0);
    in_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== '0 || count_o !== 2'd0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h count=%0d ready=%b, need 0/0/0/1",
               out_valid_o, out_data_o, count_o, in_ready_o);
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h13, 1'b1, 1'b0);
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h13) begin
      errors++;
      $display("FAIL async_recover: valid=%b data=%h, need 1/13", out_valid_o, out_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
